// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with memory-wait tracking, stall buffer and timeout flag
//
// Purpose: captures the fetched instruction into the IF/ID register. It inserts
// bubbles while instruction memory is not ready, and parks one early-arriving
// word while ID is stalled, so that no instruction is lost or duplicated.
// Optional feature macro: IF_IRQ_INJECT_EN (interrupt injection at capture).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   pc_in                fetch address from the PC stage
//   imem_rdata/ready     instruction word for pc_in and its valid strobe
//   stall, flush, irq    hazard hold, pipeline kill, pending interrupt
//   fetch_nop            combinational hold request to the PC stage
//   id_valid/pc/pc_plus4/instr/irq   registered IF/ID outputs
//   imem_timeout         sticky memory-timeout flag

module if_id_stage #(
  parameter logic [31:0] RESET_PC    = 32'h80000000,
  parameter logic [7:0]  TIMEOUT_MAX = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        irq,
  output logic        fetch_nop,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        id_irq,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HOLD     = 2'd2,
    HOLD_BUF = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        r_timeout;
  logic        w_timeout_next;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic [31:0] r_id_instr;
  logic        r_id_irq;

  logic        w_buf_valid;
  logic        w_load_id;
  logic        w_load_from_buf;
  logic        w_bubble;
  logic        w_buf_fill;
  logic [31:0] w_src_pc;
  logic [31:0] w_src_instr;
  logic        w_inject;

  // Bit 31 is the kernel bit: it is preserved and the carry out of bit 30 is dropped.
  function automatic logic [31:0] f_pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  // The one-entry buffer is full exactly when the FSM is in HOLD_BUF.
  assign w_buf_valid = (r_state == HOLD_BUF);

  assign fetch_nop = ~flush & (stall | (~imem_ready & ~w_buf_valid));

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_timeout_next  = r_timeout;
    w_load_id       = 1'b0;
    w_load_from_buf = 1'b0;
    w_bubble        = 1'b0;
    w_buf_fill      = 1'b0;
    if (flush) begin
      w_state_next = RUN;
      w_cnt_next   = 8'd0;
    end else if (stall) begin
      if (!w_buf_valid) begin
        // PC is held during a stall, so a word arriving now would otherwise be lost.
        if (imem_ready) begin
          w_buf_fill   = 1'b1;
          w_state_next = HOLD_BUF;
        end else begin
          w_state_next = HOLD;
        end
      end
    end else if (w_buf_valid) begin
      // Buffered word wins; the word on imem_rdata belongs to the same held PC.
      w_load_id       = 1'b1;
      w_load_from_buf = 1'b1;
      w_cnt_next      = 8'd0;
      w_state_next    = RUN;
    end else if (imem_ready) begin
      w_load_id    = 1'b1;
      w_cnt_next   = 8'd0;
      w_state_next = RUN;
    end else begin
      w_bubble     = 1'b1;
      w_state_next = MEM_WAIT;
      w_cnt_next   = (r_cnt == TIMEOUT_MAX) ? TIMEOUT_MAX : r_cnt + 8'd1;
      if (w_cnt_next == TIMEOUT_MAX) begin
        w_timeout_next = 1'b1;
      end
    end
  end

  assign w_src_pc    = w_load_from_buf ? r_buf_pc    : pc_in;
  assign w_src_instr = w_load_from_buf ? r_buf_instr : imem_rdata;

`ifdef IF_IRQ_INJECT_EN
  // Only user-space (bit 31 clear) instructions are replaced by an interrupt marker.
  assign w_inject = irq & ~w_src_pc[31];
`else
  // Interrupt injection disabled: irq is masked off entirely.
  assign w_inject = irq & 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_cnt         <= 8'd0;
      r_timeout     <= 1'b0;
      r_buf_pc      <= 32'd0;
      r_buf_instr   <= 32'd0;
      r_id_valid    <= 1'b0;
      r_id_pc       <= RESET_PC;
      r_id_pc_plus4 <= RESET_PC + 32'd4;
      r_id_instr    <= 32'd0;
      r_id_irq      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
      if (w_buf_fill) begin
        r_buf_pc    <= pc_in;
        r_buf_instr <= imem_rdata;
      end
      if (flush) begin
        r_id_valid <= 1'b0;
        r_id_irq   <= 1'b0;
      end else if (w_load_id) begin
        r_id_valid    <= 1'b1;
        r_id_pc       <= w_src_pc;
        r_id_pc_plus4 <= f_pc_plus4(w_src_pc);
        r_id_instr    <= w_inject ? 32'h00000000 : w_src_instr;
        r_id_irq      <= w_inject;
      end else if (w_bubble) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign id_valid     = r_id_valid;
  assign id_pc        = r_id_pc;
  assign id_pc_plus4  = r_id_pc_plus4;
  assign id_instr     = r_id_instr;
  assign id_irq       = r_id_irq;
  assign imem_timeout = r_timeout;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage

module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        flush;
  logic        irq;
  logic        fetch_nop;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_irq;
  logic        imem_timeout;

  always #5 clk = ~clk;

  if_id_stage #(.RESET_PC(32'h80000000), .TIMEOUT_MAX(8'd255)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .stall(stall), .flush(flush), .irq(irq),
    .fetch_nop(fetch_nop), .id_valid(id_valid), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .id_irq(id_irq),
    .imem_timeout(imem_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic rdy,
                       input logic iq, input logic [31:0] pc, input logic [31:0] data);
    reset = r; stall = s; flush = f; imem_ready = rdy; irq = iq;
    pc_in = pc; imem_rdata = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, check fetch_nop before the edge, then clock.
  task automatic step(input string name, input logic s, input logic f, input logic rdy,
                      input logic iq, input logic [31:0] pc, input logic [31:0] data,
                      input logic e_nop);
    drive(1'b0, s, f, rdy, iq, pc, data);
    #1;
    chk1({name, "_nop"}, fetch_nop, e_nop);
    tick();
  endtask

  task automatic idchk(input string name, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr);
    chk1({name, "_valid"}, id_valid, v);
    chk({name, "_pc"}, id_pc, pc);
    chk({name, "_instr"}, id_instr, instr);
  endtask

  typedef struct {
    logic        rst, stl, fl, rdy, iq;
    logic [31:0] pc, data;
    logic        e_nop, e_valid;
    logic [31:0] e_pc, e_p4, e_instr;
  } vec_t;

  vec_t tbl[9];

  // Reference model: IF/ID contents plus a queue holding at most one parked word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        q[$];
  logic        m_valid, m_irq, m_to;
  logic [31:0] m_pc, m_p4, m_instr;
  int          m_waits;

  task automatic m_reset();
    m_valid = 1'b0; m_irq = 1'b0; m_to = 1'b0;
    m_pc = 32'h80000000; m_p4 = 32'h80000004; m_instr = 32'd0;
    m_waits = 0;
    q.delete();
  endtask

  task automatic m_load(input logic [31:0] pc, input logic [31:0] instr, input logic iq);
    m_valid = 1'b1;
    m_pc    = pc;
    m_p4    = (pc & 32'h80000000) | ((pc + 32'd4) & 32'h7FFFFFFF);
    m_instr = instr;
    m_irq   = 1'b0;
`ifdef IF_IRQ_INJECT_EN
    if (iq && !pc[31]) begin
      m_instr = 32'd0;
      m_irq   = 1'b1;
    end
`else
    if (iq) m_irq = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0] rpc;
    logic        r_rst, r_stl, r_fl, r_rdy, r_iq, e_nop;
    logic [31:0] r_data;
    ent_t        e;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80000000, 32'h80000004, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80000000, 32'h80000004, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000, 32'h00000013, 1'b0, 1'b1, 32'h80000000, 32'h80000004, 32'h00000013};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000004, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h80000000, 32'h80000004, 32'h00000013};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000004, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h80000000, 32'h80000004, 32'h00000013};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000004, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h80000000, 32'h80000004, 32'h00000013};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000004, 32'h8C010004, 1'b0, 1'b1, 32'h80000004, 32'h80000008, 32'h8C010004};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFC, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFC, 32'h00000000, 32'h00000001};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000002, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h80000000, 32'h00000002};

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].rdy, tbl[i].iq, tbl[i].pc, tbl[i].data);
      #1;
      chk1($sformatf("vec%0d_nop", i), fetch_nop, tbl[i].e_nop);
      tick();
      chk1($sformatf("vec%0d_valid", i), id_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_pc", i), id_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_p4", i), id_pc_plus4, tbl[i].e_p4);
      chk($sformatf("vec%0d_instr", i), id_instr, tbl[i].e_instr);
      chk1($sformatf("vec%0d_irq", i), id_irq, 1'b0);
      chk1($sformatf("vec%0d_to", i), imem_timeout, 1'b0);
    end

    // Stall with a word arriving mid-stall: it must be parked, then delivered once.
    step("st_a", 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000100, 32'h0, 1'b1);
    idchk("st_a", 1'b1, 32'hFFFFFFFC, 32'h00000002);
    for (int i = 0; i < 3; i++) begin
      step("st_b", 1'b1, 1'b0, 1'b1, 1'b0, 32'h80000100, 32'h11111111, 1'b1);
      idchk("st_b", 1'b1, 32'hFFFFFFFC, 32'h00000002);
    end
    step("st_rel", 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000100, 32'hDEADBEEF, 1'b0);
    idchk("st_rel", 1'b1, 32'h80000100, 32'h11111111);
    chk("st_rel_p4", id_pc_plus4, 32'h80000104);
    step("st_nxt", 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000104, 32'h22222222, 1'b0);
    idchk("st_nxt", 1'b1, 32'h80000104, 32'h22222222);

    // Flush while a word is parked: buffer must be dropped.
    step("fl_a", 1'b1, 1'b0, 1'b1, 1'b0, 32'h80000200, 32'h33333333, 1'b1);
    step("fl_b", 1'b1, 1'b1, 1'b1, 1'b0, 32'h80000200, 32'h33333333, 1'b0);
    idchk("fl_b", 1'b0, 32'h80000104, 32'h22222222);
    step("fl_emp", 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000300, 32'h0, 1'b1);
    chk1("fl_emp_valid", id_valid, 1'b0);
    step("fl_cap", 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000300, 32'h44444444, 1'b0);
    idchk("fl_cap", 1'b1, 32'h80000300, 32'h44444444);

    // Timeout: 254 waits stay clear, the 255th sets it, it is sticky until reset.
    for (int i = 0; i < 254; i++) begin
      step("to_w", 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000304, 32'h0, 1'b1);
    end
    chk1("to_254", imem_timeout, 1'b0);
    chk1("to_254_valid", id_valid, 1'b0);
    step("to_w", 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000304, 32'h0, 1'b1);
    chk1("to_255", imem_timeout, 1'b1);
    step("to_cap", 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000304, 32'h77777777, 1'b0);
    chk1("to_sticky", imem_timeout, 1'b1);
    idchk("to_cap", 1'b1, 32'h80000304, 32'h77777777);
    for (int i = 0; i < 10; i++) begin
      step("to_sat", 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000308, 32'h0, 1'b1);
    end
    chk1("to_sat", imem_timeout, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk1("to_rst", imem_timeout, 1'b0);

    // Interrupt injection at capture.
    step("irq_u", 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400010, 32'h55555555, 1'b0);
`ifdef IF_IRQ_INJECT_EN
    idchk("irq_u", 1'b1, 32'h00400010, 32'h00000000);
    chk1("irq_u_irq", id_irq, 1'b1);
`else
    idchk("irq_u", 1'b1, 32'h00400010, 32'h55555555);
    chk1("irq_u_irq", id_irq, 1'b0);
`endif
    step("irq_k", 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000010, 32'h66666666, 1'b0);
    idchk("irq_k", 1'b1, 32'h80000010, 32'h66666666);
    chk1("irq_k_irq", id_irq, 1'b0);

    // Randomized run against the reference model with a PC stage emulation.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    m_reset();
    rpc = 32'h80000000;
    for (int c = 0; c < 3000; c++) begin
      r_rst  = ($urandom_range(0, 299) == 0);
      r_stl  = ($urandom_range(0, 3) == 0);
      r_fl   = ($urandom_range(0, 11) == 0);
      r_rdy  = ($urandom_range(0, 9) < 7);
      r_iq   = ($urandom_range(0, 3) == 0);
      r_data = $urandom;
      if (c >= 1500 && c < 1800) begin
        r_rst = 1'b0; r_fl = 1'b0; r_rdy = 1'b0;
      end
      drive(r_rst, r_stl, r_fl, r_rdy, r_iq, rpc, r_data);
      #1;
      e_nop = !r_fl && (r_stl || (!r_rdy && q.size() == 0));
      chk1("rnd_nop", fetch_nop, e_nop);

      if (r_rst) begin
        m_reset();
      end else if (r_fl) begin
        m_valid = 1'b0; m_irq = 1'b0; m_waits = 0;
        q.delete();
      end else if (r_stl) begin
        if (q.size() == 0 && r_rdy) q.push_back('{rpc, r_data});
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_load(e.pc, e.instr, r_iq);
        m_waits = 0;
      end else if (r_rdy) begin
        m_load(rpc, r_data, r_iq);
        m_waits = 0;
      end else begin
        m_valid = 1'b0;
        m_waits++;
        if (m_waits >= 255) m_to = 1'b1;
      end

      tick();
      chk1("rnd_valid", id_valid, m_valid);
      chk("rnd_pc", id_pc, m_pc);
      chk("rnd_p4", id_pc_plus4, m_p4);
      chk("rnd_instr", id_instr, m_instr);
      chk1("rnd_irq", id_irq, m_irq);
      chk1("rnd_to", imem_timeout, m_to);

      if (r_rst)       rpc = 32'h80000000;
      else if (r_fl)   rpc = {$urandom_range(0, 1) == 1, 19'd0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (!e_nop) rpc = rpc + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
